// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg -- shared definitions for the SRAM arbiter slice.
// Holds the requester ordinals, default geometry, FSM state encodings and a
// small ID-to-one-hot helper used by the arbiter and its tests.
package sram_arbiter_pkg;

  // Default SRAM geometry (ZBT part, 512K x 36).
  localparam int DEF_ADDR_W   = 19;
  localparam int DEF_DATA_W   = 36;
  localparam int DEF_READ_LAT = 2;

  localparam int NUM_REQ  = 4;
  localparam int REQ_ID_W = 2;

  // Requester ordinals: bit index into req/wr/grant/rvalid and slice index
  // into addr/wdata.
  localparam logic [1:0] REQ_NTSC = 2'd0;
  localparam logic [1:0] REQ_LPF  = 2'd1;
  localparam logic [1:0] REQ_PT   = 2'd2;
  localparam logic [1:0] REQ_VGA  = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_e;

  // Requester ID -> one-hot requester vector.
  function automatic logic [3:0] id_to_onehot(input logic [1:0] id);
    id_to_onehot = 4'b0001 << id;
  endfunction

endpackage

// File: rtl/sram_read_tag_queue.sv
// sram_read_tag_queue -- fixed-length shift register of {valid, ID} tags.
// One entry is pushed every cycle (valid=0 for idle/write cycles); the entry
// at the tail emerges exactly DEPTH cycles later.
// Ports:
//   clock, reset   clock and asynchronous active-low reset
//   push_valid_i   tag valid for this cycle's transfer
//   push_id_i      requester ID of this cycle's transfer
//   head_valid_o   oldest stage valid
//   head_id_o      oldest stage requester ID
//   empty_o        no stage holds a valid tag
module sram_read_tag_queue #(
  parameter int DEPTH = 3,
  parameter int ID_W  = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push_valid_i,
  input  logic [ID_W-1:0] push_id_i,
  output logic            head_valid_o,
  output logic [ID_W-1:0] head_id_o,
  output logic            empty_o
);

  logic [DEPTH-1:0] vld_q;
  logic [ID_W-1:0]  id_q [DEPTH];

  // Tag shift register: stage 0 takes the new tag, every stage advances by one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= push_valid_i;
      id_q[0]  <= push_id_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

  assign head_valid_o = vld_q[DEPTH-1];
  assign head_id_o    = id_q[DEPTH-1];
  assign empty_o      = ~|vld_q;

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter -- four-requester arbiter in front of a ZBT (late-write) SRAM.
// Priority VGA > NTSC > {LPF, PT}. One transfer per cycle, no stalls on
// read/write mixes. A flush drains in-flight reads and writes, then pulses
// flush_done for one cycle.
// Build option: define SRAM_ARB_RR_EN to arbitrate LPF/PT round-robin;
// otherwise LPF has fixed priority over PT.
// Ports:
//   clock, reset         clock and asynchronous active-low reset
//   req/wr/addr/wdata    per-requester request, direction, address, data
//   flush                frame-boundary drain request
//   grant                one-hot combinational grant
//   rvalid, rdata        one-hot read-valid tag and registered read data
//   flush_done           one-cycle drain-complete pulse
//   ram_*                SRAM address/control/data pins
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int READ_LAT = DEF_READ_LAT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [3:0]          req,
  input  logic [3:0]          wr,
  input  logic [4*ADDR_W-1:0] addr,
  input  logic [4*DATA_W-1:0] wdata,
  input  logic                flush,
  output logic [3:0]          grant,
  output logic [3:0]          rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                flush_done,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_we_b,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic                ram_wdata_oe,
  input  logic [DATA_W-1:0]   ram_rdata
);

  arb_state_e state_q, state_d;

  logic [3:0]        grant_int;
  logic [1:0]        sel_id;
  logic              xfer;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_we_b_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              ram_wdata_oe_q;
  logic [3:0]        rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  // Write-data delay line: stage k holds data for the SRAM bus k+1 cycles
  // after the address phase; the output register adds the final cycle.
  logic [READ_LAT-1:0] wdl_vld_q;
  logic [DATA_W-1:0]   wdl_data_q [READ_LAT];

  logic       tag_head_vld;
  logic [1:0] tag_head_id;
  logic       tag_empty;

`ifdef SRAM_ARB_RR_EN
  logic rr_q;  // 0: LPF favoured on a tie, 1: PT favoured
`endif

  // Arbitration and FSM next state.
  always_comb begin
    state_d   = state_q;
    grant_int = 4'b0000;
    sel_id    = REQ_NTSC;
    case (state_q)
      ST_RUN: begin
        if (req[REQ_VGA]) begin
          sel_id = REQ_VGA;
        end else if (req[REQ_NTSC]) begin
          sel_id = REQ_NTSC;
`ifdef SRAM_ARB_RR_EN
        end else if (req[REQ_LPF] && (!req[REQ_PT] || !rr_q)) begin
          sel_id = REQ_LPF;
`else
        end else if (req[REQ_LPF]) begin
          sel_id = REQ_LPF;
`endif
        end else begin
          sel_id = REQ_PT;
        end
        if (|req) begin
          grant_int = id_to_onehot(sel_id);
        end else begin
          grant_int = 4'b0000;
        end
        // A request coinciding with flush is still granted this cycle.
        if (flush) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (tag_empty && !(|wdl_vld_q)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign grant     = reset ? grant_int : 4'b0000;
  assign xfer      = |grant;
  assign sel_wr    = wr[sel_id];
  assign sel_addr  = addr[int'(sel_id)*ADDR_W +: ADDR_W];
  assign sel_wdata = wdata[int'(sel_id)*DATA_W +: DATA_W];

  sram_read_tag_queue #(
    .DEPTH (READ_LAT + 1),
    .ID_W  (REQ_ID_W)
  ) u_tag_queue (
    .clock        (clock),
    .reset        (reset),
    .push_valid_i (xfer & ~sel_wr),
    .push_id_i    (sel_id),
    .head_valid_o (tag_head_vld),
    .head_id_o    (tag_head_id),
    .empty_o      (tag_empty)
  );

  // State, SRAM address phase, write-data pipeline and read-return registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_RUN;
      ram_addr_q     <= '0;
      ram_we_b_q     <= 1'b1;
      ram_wdata_q    <= '0;
      ram_wdata_oe_q <= 1'b0;
      rvalid_q       <= 4'b0000;
      rdata_q        <= '0;
      wdl_vld_q      <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        wdl_data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      // Idle cycles keep the last address and deassert write enable.
      if (xfer) begin
        ram_addr_q <= sel_addr;
        ram_we_b_q <= ~sel_wr;
      end else begin
        ram_we_b_q <= 1'b1;
      end
      wdl_vld_q[0]  <= xfer & sel_wr;
      wdl_data_q[0] <= sel_wdata;
      for (int i = 1; i < READ_LAT; i++) begin
        wdl_vld_q[i]  <= wdl_vld_q[i-1];
        wdl_data_q[i] <= wdl_data_q[i-1];
      end
      ram_wdata_oe_q <= wdl_vld_q[READ_LAT-1];
      if (wdl_vld_q[READ_LAT-1]) begin
        ram_wdata_q <= wdl_data_q[READ_LAT-1];
      end else begin
        ram_wdata_q <= ram_wdata_q;
      end
      // The tag head lines up with read data arriving on ram_rdata.
      if (tag_head_vld) begin
        rvalid_q <= id_to_onehot(tag_head_id);
        rdata_q  <= ram_rdata;
      end else begin
        rvalid_q <= 4'b0000;
        rdata_q  <= rdata_q;
      end
    end
  end

`ifdef SRAM_ARB_RR_EN
  // Round-robin pointer flips after every LPF or PT grant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_q <= 1'b0;
    end else if (xfer && (sel_id == REQ_LPF || sel_id == REQ_PT)) begin
      rr_q <= ~rr_q;
    end else begin
      rr_q <= rr_q;
    end
  end
`endif

  assign flush_done   = (state_q == ST_DONE);
  assign ram_addr     = ram_addr_q;
  assign ram_we_b     = ram_we_b_q;
  assign ram_wdata    = ram_wdata_q;
  assign ram_wdata_oe = ram_wdata_oe_q;
  assign rvalid       = rvalid_q;
  assign rdata        = rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter -- directed self-checking bench for sram_arbiter
// (ADDR_W=19, DATA_W=36, READ_LAT=2). The SRAM model returns data two cycles
// after the address phase: 0x123456789 for address 0x00010, otherwise the
// zero-extended address. Honours SRAM_ARB_RR_EN for the LPF/PT expectations.
module tb_sram_arbiter;

  localparam int AW = 19;
  localparam int DW = 36;
  localparam int RL = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [3:0]    req;
  logic [3:0]    wr;
  logic [4*AW-1:0] addr;
  logic [4*DW-1:0] wdata;
  logic          flush;
  logic [3:0]    grant;
  logic [3:0]    rvalid;
  logic [DW-1:0] rdata;
  logic          flush_done;
  logic [AW-1:0] ram_addr;
  logic          ram_we_b;
  logic [DW-1:0] ram_wdata;
  logic          ram_wdata_oe;
  logic [DW-1:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] p0 = '0;
  logic [AW-1:0] p1 = '0;
  logic [3:0]    exp_rr [4];

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL)) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .wr           (wr),
    .addr         (addr),
    .wdata        (wdata),
    .flush        (flush),
    .grant        (grant),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .flush_done   (flush_done),
    .ram_addr     (ram_addr),
    .ram_we_b     (ram_we_b),
    .ram_wdata    (ram_wdata),
    .ram_wdata_oe (ram_wdata_oe),
    .ram_rdata    (ram_rdata)
  );

  always #5 clock = ~clock;

  // Pipelined SRAM read model: address phase in cycle N, data in cycle N+2.
  always @(posedge clock) begin
    p0 <= ram_addr;
    p1 <= p0;
  end
  assign ram_rdata = (p1 == 19'h00010) ? 36'h123456789 : {17'h00000, p1};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
`ifdef SRAM_ARB_RR_EN
    exp_rr[0] = 4'b0010; exp_rr[1] = 4'b0100; exp_rr[2] = 4'b0010; exp_rr[3] = 4'b0100;
`else
    exp_rr[0] = 4'b0010; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b0010; exp_rr[3] = 4'b0010;
`endif
    reset = 1'b0; req = 4'b0000; wr = 4'b0000; addr = '0; wdata = '0; flush = 1'b0;

    // Reset values, grant gated while in reset even with all requests high.
    #2;
    req = 4'b1111;
    #1;
    chk("rst_grant", {60'd0, grant}, 64'd0);
    tick();
    chk("rst_rvalid", {60'd0, rvalid}, 64'd0);
    chk("rst_rdata", {28'd0, rdata}, 64'd0);
    chk("rst_flush_done", {63'd0, flush_done}, 64'd0);
    chk("rst_we_b", {63'd0, ram_we_b}, 64'd1);
    chk("rst_oe", {63'd0, ram_wdata_oe}, 64'd0);
    chk("rst_addr", {45'd0, ram_addr}, 64'd0);
    chk("rst_wdata", {28'd0, ram_wdata}, 64'd0);
    req = 4'b0000;
    reset = 1'b1;
    tick();

    // Priority: all four -> VGA; without VGA -> NTSC; dropped before the edge.
    req = 4'b1111; #1;
    chk("prio_all", {60'd0, grant}, 64'h8);
    req = 4'b0111; #1;
    chk("prio_ntsc", {60'd0, grant}, 64'h1);
    req = 4'b0000; #1;
    chk("idle_grant", {60'd0, grant}, 64'd0);
    tick();
    chk("idle_we_b", {63'd0, ram_we_b}, 64'd1);
    chk("idle_addr", {45'd0, ram_addr}, 64'd0);

    // VGA read of 0x00010 in cycle T.
    req = 4'b1000; wr = 4'b0000; addr[3*AW +: AW] = 19'h00010; #1;
    chk("rd_grant", {60'd0, grant}, 64'h8);
    tick();  // T+1
    req = 4'b0000;
    chk("rd_addr", {45'd0, ram_addr}, 64'h10);
    chk("rd_we_b", {63'd0, ram_we_b}, 64'd1);
    chk("rd_rvalid_t1", {60'd0, rvalid}, 64'd0);
    tick();  // T+2
    chk("rd_rvalid_t2", {60'd0, rvalid}, 64'd0);
    tick();  // T+3
    chk("rd_rvalid_t3", {60'd0, rvalid}, 64'd0);
    chk("rd_no_oe_t3", {63'd0, ram_wdata_oe}, 64'd0);
    tick();  // T+4
    chk("rd_rvalid_t4", {60'd0, rvalid}, 64'h8);
    chk("rd_rdata_t4", {28'd0, rdata}, 64'h123456789);
    tick();  // T+5
    chk("rd_rvalid_t5", {60'd0, rvalid}, 64'd0);
    chk("rd_rdata_hold", {28'd0, rdata}, 64'h123456789);

    // NTSC write of 0xABC to 0x00005 in cycle T.
    req = 4'b0001; wr = 4'b0001; addr[0 +: AW] = 19'h00005; wdata[0 +: DW] = 36'h000000ABC; #1;
    chk("wr_grant", {60'd0, grant}, 64'h1);
    tick();  // T+1
    req = 4'b0000; wr = 4'b0000;
    chk("wr_addr", {45'd0, ram_addr}, 64'h5);
    chk("wr_we_b", {63'd0, ram_we_b}, 64'd0);
    chk("wr_oe_t1", {63'd0, ram_wdata_oe}, 64'd0);
    tick();  // T+2
    chk("wr_we_b_idle", {63'd0, ram_we_b}, 64'd1);
    chk("wr_addr_hold", {45'd0, ram_addr}, 64'h5);
    chk("wr_oe_t2", {63'd0, ram_wdata_oe}, 64'd0);
    tick();  // T+3
    chk("wr_wdata_t3", {28'd0, ram_wdata}, 64'hABC);
    chk("wr_oe_t3", {63'd0, ram_wdata_oe}, 64'd1);
    tick();  // T+4
    chk("wr_oe_t4", {63'd0, ram_wdata_oe}, 64'd0);

    // LPF and PT held together for four cycles (writes).
    req = 4'b0110; wr = 4'b0110;
    wdata[1*DW +: DW] = 36'h000000111; wdata[2*DW +: DW] = 36'h000000222;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("lpf_pt_%0d", k), {60'd0, grant}, {60'd0, exp_rr[k]});
      tick();
    end
    req = 4'b0000; wr = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      tick();
    end

    // Flush with three NTSC reads in flight; flush coincides with the third.
    req = 4'b0001; wr = 4'b0000; addr[0 +: AW] = 19'h00021; #1;
    chk("fl_grant_a0", {60'd0, grant}, 64'h1);
    tick();
    addr[0 +: AW] = 19'h00022; #1;
    chk("fl_grant_a1", {60'd0, grant}, 64'h1);
    tick();
    addr[0 +: AW] = 19'h00023; flush = 1'b1; #1;
    chk("fl_grant_a2", {60'd0, grant}, 64'h1);
    tick();  // A+3
    flush = 1'b0; req = 4'b1001; #1;
    chk("fl_grant_a3", {60'd0, grant}, 64'd0);
    chk("fl_done_a3", {63'd0, flush_done}, 64'd0);
    chk("fl_rvalid_a3", {60'd0, rvalid}, 64'd0);
    tick();  // A+4
    flush = 1'b1;
    chk("fl_rvalid_a4", {60'd0, rvalid}, 64'h1);
    chk("fl_rdata_a4", {28'd0, rdata}, 64'h21);
    #1;
    chk("fl_grant_a4", {60'd0, grant}, 64'd0);
    chk("fl_done_a4", {63'd0, flush_done}, 64'd0);
    tick();  // A+5
    flush = 1'b0;
    chk("fl_rvalid_a5", {60'd0, rvalid}, 64'h1);
    chk("fl_rdata_a5", {28'd0, rdata}, 64'h22);
    chk("fl_grant_a5", {60'd0, grant}, 64'd0);
    tick();  // A+6
    chk("fl_rvalid_a6", {60'd0, rvalid}, 64'h1);
    chk("fl_rdata_a6", {28'd0, rdata}, 64'h23);
    chk("fl_grant_a6", {60'd0, grant}, 64'd0);
    chk("fl_done_a6", {63'd0, flush_done}, 64'd0);
    tick();  // A+7 (DONE)
    chk("fl_done_a7", {63'd0, flush_done}, 64'd1);
    chk("fl_rvalid_a7", {60'd0, rvalid}, 64'd0);
    chk("fl_grant_a7", {60'd0, grant}, 64'd0);
    flush = 1'b1;
    tick();  // A+8 (RUN)
    flush = 1'b0;
    chk("fl_done_a8", {63'd0, flush_done}, 64'd0);
    #1;
    chk("fl_grant_a8", {60'd0, grant}, 64'h8);
    req = 4'b0000;
    tick();

    // Reset asserted one cycle after a VGA read grant.
    req = 4'b1000; wr = 4'b0000; addr[3*AW +: AW] = 19'h00010; #1;
    chk("mr_grant", {60'd0, grant}, 64'h8);
    tick();  // T+1
    req = 4'b0000;
    reset = 1'b0;
    #1;
    chk("mr_we_b", {63'd0, ram_we_b}, 64'd1);
    chk("mr_addr", {45'd0, ram_addr}, 64'd0);
    chk("mr_rdata", {28'd0, rdata}, 64'd0);
    chk("mr_oe", {63'd0, ram_wdata_oe}, 64'd0);
    chk("mr_wdata", {28'd0, ram_wdata}, 64'd0);
    tick();  // T+2
    reset = 1'b1;
    for (int k = 3; k < 7; k++) begin
      tick();
      chk($sformatf("mr_rvalid_t%0d", k), {60'd0, rvalid}, 64'd0);
      chk($sformatf("mr_rdata_t%0d", k), {28'd0, rdata}, 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
